udp_tx_feeder: RTL and testbench

//  Transmit-side buffer feeding the UDP master channel. Accepts 64-bit FEC-encoded words,

---
 rtl/udp_tx_feeder.sv | 136 +++++++++++++
 tb/tb_udp_tx_feeder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_feeder.sv
// Transmit-side FWFT FIFO feeding the UDP master channel, with a word counter and completion flag.
// Optional macro UDP_TX_LAST_FLAG_EN: bit DATA_W-1 of data_in marks the final word of a transfer.
module udp_tx_feeder #(
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned DEPTH_LOG2 = 9,
    parameter int unsigned LEN_W      = 56
) (
    input  logic                  clk_15_625,
    input  logic                  core_reset,
    input  logic                  s_valid,
    input  logic [DATA_W-1:0]     s_data,
    output logic                  s_ready,
    input  logic                  start,
    input  logic [LEN_W-1:0]      tx_data_len,
    output logic                  data_read_ready,
    input  logic                  data_in_req,
    output logic [DATA_W-1:0]     data_in,
    output logic [LEN_W-1:0]      words_sent,
    output logic [DEPTH_LOG2:0]   fifo_level,
    output logic                  done,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int unsigned LVL_W = DEPTH_LOG2 + 1;
    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    logic [DATA_W-1:0]     mem [DEPTH];
    state_t                state_q, state_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic [LEN_W-1:0]      len_q, len_d, words_sent_q, words_sent_d;
    logic                  done_q, done_d, overflow_q, overflow_d, underflow_q, underflow_d;
    logic                  full, empty, rd_ok, push, pop;

    always_comb begin
        full  = (level_q == LVL_W'(DEPTH));
        empty = (level_q == '0);
        rd_ok = (state_q == RUN) && !empty;
        push  = s_valid && !full;
        pop   = data_in_req && rd_ok;

        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        len_d        = len_q;
        words_sent_d = words_sent_q;
        done_d       = done_q;
        overflow_d   = overflow_q;
        underflow_d  = underflow_q;

        if (push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        if (s_valid && full)      overflow_d  = 1'b1;
        if (data_in_req && !rd_ok) underflow_d = 1'b1;

        case (state_q)
            RUN: begin
                if (pop) begin
                    words_sent_d = words_sent_q + LEN_W'(1);
                    if (words_sent_q == len_q - LEN_W'(1)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                if (start) begin
                    words_sent_d = '0;
                    if (tx_data_len != '0) begin
                        state_d = RUN;
                        len_d   = tx_data_len;
                        done_d  = 1'b0;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_15_625) begin
        if (core_reset) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            len_q        <= '0;
            words_sent_q <= '0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            len_q        <= len_d;
            words_sent_q <= words_sent_d;
            done_q       <= done_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    // Storage is not reset: clearing the level is what discards the contents.
    always_ff @(posedge clk_15_625) begin
        if (push) mem[wr_ptr_q] <= s_data;
    end

`ifdef UDP_TX_LAST_FLAG_EN
    logic last_word;
    logic [DATA_W-1:0] head;
    assign last_word = (state_q == RUN) && (words_sent_q == len_q - LEN_W'(1));
    assign head      = mem[rd_ptr_q];
    assign data_in   = {last_word, head[DATA_W-2:0]};
`else
    assign data_in   = mem[rd_ptr_q];
`endif

    assign s_ready         = !full;
    assign data_read_ready = rd_ok;
    assign words_sent      = words_sent_q;
    assign fifo_level      = level_q;
    assign done            = done_q;
    assign overflow        = overflow_q;
    assign underflow       = underflow_q;
endmodule

// File: tb/tb_udp_tx_feeder.sv
// Scoreboard bench for udp_tx_feeder: accepted words are queued and checked as they are popped.
module tb_udp_tx_feeder;
    logic        clk_15_625 = 1'b0;
    logic        core_reset;
    logic        s_valid;
    logic [63:0] s_data;
    logic        s_ready;
    logic        start;
    logic [55:0] tx_data_len;
    logic        data_read_ready;
    logic        data_in_req;
    logic [63:0] data_in;
    logic [55:0] words_sent;
    logic [9:0]  fifo_level;
    logic        done, overflow, underflow;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [63:0] sb[$];
    logic [55:0] tb_len;
    logic [55:0] tb_sent;
    logic        tb_run;

    udp_tx_feeder #(.DATA_W(64), .DEPTH_LOG2(9), .LEN_W(56)) dut (
        .clk_15_625(clk_15_625), .core_reset(core_reset),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .start(start), .tx_data_len(tx_data_len),
        .data_read_ready(data_read_ready), .data_in_req(data_in_req), .data_in(data_in),
        .words_sent(words_sent), .fifo_level(fifo_level),
        .done(done), .overflow(overflow), .underflow(underflow)
    );

    always #32 clk_15_625 = ~clk_15_625;

    task automatic tick();
        @(posedge clk_15_625);
        #1;
    endtask

    function automatic logic [63:0] exp_head(input logic [63:0] w, input logic last);
`ifdef UDP_TX_LAST_FLAG_EN
        return {last, w[62:0]};
`else
        return last ? w : w;
`endif
    endfunction

    task automatic apply_reset();
        core_reset = 1'b1; s_valid = 1'b0; data_in_req = 1'b0; start = 1'b0;
        tick();
        core_reset = 1'b0;
        sb.delete();
        tb_run = 1'b0; tb_sent = '0; tb_len = '0;
    endtask

    task automatic do_start(input logic [55:0] len);
        start = 1'b1; tx_data_len = len;
        tick();
        start = 1'b0;
        tb_len = len; tb_sent = '0; tb_run = (len != '0);
    endtask

    task automatic push_word(input logic [63:0] w);
        s_valid = 1'b1; s_data = w;
        if (s_ready) sb.push_back(w);
        tick();
        s_valid = 1'b0;
    endtask

    // Checks the head against the scoreboard, optionally pushing a new word on the same edge.
    task automatic pop_word(input logic do_push, input logic [63:0] w);
        logic [63:0] exp;
        n_cmp++;
        if (data_read_ready !== 1'b1) begin
            n_err++;
            $display("FAIL pop_ready: data_read_ready=%b required 1 (sent %0d)", data_read_ready, tb_sent);
        end
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL pop_sb: pop with empty scoreboard, data_in=%h required none", data_in);
        end else begin
            exp = exp_head(sb.pop_front(), tb_run && (tb_sent == tb_len - 56'd1));
            n_cmp++;
            if (data_in !== exp) begin
                n_err++;
                $display("FAIL pop_data: data_in=%h required %h (sent %0d)", data_in, exp, tb_sent);
            end
        end
        if (do_push) begin
            s_valid = 1'b1; s_data = w;
            if (s_ready) sb.push_back(w);
        end
        data_in_req = 1'b1;
        tick();
        data_in_req = 1'b0; s_valid = 1'b0;
        tb_sent++;
        if (tb_run && tb_sent == tb_len) tb_run = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({s_ready, data_read_ready, done, overflow, underflow} !== 5'b10000) begin
            n_err++;
            $display("FAIL reset_flags: rdy/drr/done/ovf/unf=%b required 10000",
                     {s_ready, data_read_ready, done, overflow, underflow});
        end
        n_cmp++;
        if (fifo_level !== 10'd0 || words_sent !== 56'd0) begin
            n_err++;
            $display("FAIL reset_counts: level=%0d sent=%0d required 0/0", fifo_level, words_sent);
        end
    endtask

    task automatic test_basic();
        apply_reset();
        for (int i = 1; i <= 4; i++) push_word(64'(i));
        do_start(56'd4);
        for (int i = 0; i < 4; i++) pop_word(1'b0, '0);
        n_cmp++;
        if (done !== 1'b1 || words_sent !== 56'd4 || data_read_ready !== 1'b0) begin
            n_err++;
            $display("FAIL basic_done: done=%b sent=%0d drr=%b required 1/4/0", done, words_sent, data_read_ready);
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int i = 0; i < 512; i++) push_word(64'h1000 + 64'(i));
        n_cmp++;
        if (fifo_level !== 10'd512 || s_ready !== 1'b0 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL full_state: level=%0d rdy=%b ovf=%b required 512/0/0", fifo_level, s_ready, overflow);
        end
        push_word(64'hDEAD);
        n_cmp++;
        if (overflow !== 1'b1 || fifo_level !== 10'd512) begin
            n_err++;
            $display("FAIL overflow: ovf=%b level=%0d required 1/512", overflow, fifo_level);
        end
        do_start(56'd600);
        pop_word(1'b0, '0);
        pop_word(1'b1, 64'h5000);
        n_cmp++;
        if (fifo_level !== 10'd511) begin
            n_err++;
            $display("FAIL push_pop_level: level=%0d required 511", fifo_level);
        end
        for (int i = 0; i < 511; i++) pop_word(1'b0, '0);
        n_cmp++;
        if (fifo_level !== 10'd0 || data_read_ready !== 1'b0 || words_sent !== 56'd513) begin
            n_err++;
            $display("FAIL drain: level=%0d drr=%b sent=%0d required 0/0/513", fifo_level, data_read_ready, words_sent);
        end
    endtask

    task automatic test_underflow();
        apply_reset();
        do_start(56'd3);
        data_in_req = 1'b1;
        tick();
        data_in_req = 1'b0;
        n_cmp++;
        if (underflow !== 1'b1 || words_sent !== 56'd0 || fifo_level !== 10'd0) begin
            n_err++;
            $display("FAIL underflow: unf=%b sent=%0d level=%0d required 1/0/0", underflow, words_sent, fifo_level);
        end
        for (int i = 0; i < 3; i++) push_word(64'h20 + 64'(i));
        for (int i = 0; i < 3; i++) pop_word(1'b0, '0);
        n_cmp++;
        if (done !== 1'b1 || words_sent !== 56'd3) begin
            n_err++;
            $display("FAIL underflow_done: done=%b sent=%0d required 1/3", done, words_sent);
        end
    endtask

    task automatic test_last_flag();
        logic [63:0] exp2;
        apply_reset();
        do_start(56'd2);
        push_word(64'h1);
        push_word(64'h2);
        pop_word(1'b0, '0);
`ifdef UDP_TX_LAST_FLAG_EN
        exp2 = 64'h8000_0000_0000_0002;
`else
        exp2 = 64'h2;
`endif
        n_cmp++;
        if (data_in !== exp2) begin
            n_err++;
            $display("FAIL last_flag: data_in=%h required %h", data_in, exp2);
        end
        pop_word(1'b0, '0);
        n_cmp++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL last_flag_done: done=%b required 1", done);
        end
    endtask

    task automatic test_zero_len_and_reset();
        apply_reset();
        do_start(56'd0);
        n_cmp++;
        if (done !== 1'b1 || data_read_ready !== 1'b0 || words_sent !== 56'd0) begin
            n_err++;
            $display("FAIL zero_len: done=%b drr=%b sent=%0d required 1/0/0", done, data_read_ready, words_sent);
        end
        do_start(56'd5);
        n_cmp++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL restart_done: done=%b required 0", done);
        end
        for (int i = 0; i < 5; i++) push_word(64'h40 + 64'(i));
        pop_word(1'b0, '0);
        pop_word(1'b0, '0);
        n_cmp++;
        if (words_sent !== 56'd2 || fifo_level !== 10'd3) begin
            n_err++;
            $display("FAIL mid_run: sent=%0d level=%0d required 2/3", words_sent, fifo_level);
        end
        apply_reset();
        n_cmp++;
        if (fifo_level !== 10'd0 || words_sent !== 56'd0 || done !== 1'b0 || data_read_ready !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset: level=%0d sent=%0d done=%b drr=%b required 0/0/0/0",
                     fifo_level, words_sent, done, data_read_ready);
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        do_start(56'd700);
        for (int i = 0; i < 8; i++) push_word(64'h7000 + 64'(i));
        for (int i = 8; i < 700; i++) pop_word(1'b1, 64'h7000 + 64'(i));
        n_cmp++;
        if (fifo_level !== 10'd8 || words_sent !== 56'd692) begin
            n_err++;
            $display("FAIL wrap_steady: level=%0d sent=%0d required 8/692", fifo_level, words_sent);
        end
        for (int i = 0; i < 8; i++) pop_word(1'b0, '0);
        n_cmp++;
        if (done !== 1'b1 || words_sent !== 56'd700 || fifo_level !== 10'd0) begin
            n_err++;
            $display("FAIL wrap_done: done=%b sent=%0d level=%0d required 1/700/0", done, words_sent, fifo_level);
        end
    endtask

    initial begin
        core_reset = 1'b1; s_valid = 1'b0; s_data = '0; start = 1'b0;
        tx_data_len = '0; data_in_req = 1'b0;
        tb_run = 1'b0; tb_sent = '0; tb_len = '0;
        tick();
        tick();
        core_reset = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_underflow();
        test_last_flag();
        test_zero_len_and_reset();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
